// File: rtl/alu_mdu.sv
// Execute unit: decodes ALU/M-extension function fields, runs integer ops in one
// cycle and multiply/divide iteratively behind an in/out valid-ready handshake.
package alu_mdu_pkg;
    typedef enum logic [1:0] {
        ALU_OP__MEMORY_ACCESS      = 2'd0,
        ALU_OP__BRANCH             = 2'd1,
        ALU_OP__REGISTER_OPERATION = 2'd2,
        ALU_OP__UNSET              = 2'd3
    } alu_op_t;
endpackage

module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg, opnd_next;
    logic              neg_reg, neg_next;
    logic              neg_rem_reg, neg_rem_next;
    logic              sel_reg, sel_next;
    logic [XLEN-1:0]   result_reg, result_next;
    logic              illegal_reg, illegal_next;

    op_t               op, base_op, m_op;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res, mag_a, mag_b;
    logic              signed_a, signed_b, neg_a, neg_b, is_rem, div_ovf;

    always_comb begin
        base_op = OP_ADD;
        m_op    = OP_MUL;
        case (funct3)
            3'd0: begin base_op = OP_ADD;  m_op = OP_MUL;    end
            3'd1: begin base_op = OP_SLL;  m_op = OP_MULH;   end
            3'd2: begin base_op = OP_SLT;  m_op = OP_MULHSU; end
            3'd3: begin base_op = OP_SLTU; m_op = OP_MULHU;  end
            3'd4: begin base_op = OP_XOR;  m_op = OP_DIV;    end
            3'd5: begin base_op = OP_SRL;  m_op = OP_DIVU;   end
            3'd6: begin base_op = OP_OR;   m_op = OP_REM;    end
            default: begin base_op = OP_AND; m_op = OP_REMU; end
        endcase

        op = OP_ILL;
        case (alu_op)
            ALU_OP__MEMORY_ACCESS: op = OP_ADD;
            ALU_OP__BRANCH:        op = OP_SUB;
            ALU_OP__REGISTER_OPERATION: begin
                if (funct7 == 7'h00) begin
                    op = base_op;
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'b000)      op = OP_SUB;
                    else if (funct3 == 3'b101) op = OP_SRA;
                end else if (funct7 == 7'h01) begin
                    op = m_op;
                end
            end
            // I-type: the immediate's upper bits only matter for the SRAI/SRLI split
            default: op = (funct3 == 3'b101 && funct7[5]) ? OP_SRA : base_op;
        endcase
    end

    assign shamt    = src_b[SHW-1:0];
    assign signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign neg_a    = signed_a && src_a[XLEN-1];
    assign neg_b    = signed_b && src_b[XLEN-1];
    assign mag_a    = neg_a ? -src_a : src_a;
    assign mag_b    = neg_b ? -src_b : src_b;
    assign is_rem   = (op == OP_REM) || (op == OP_REMU);
    assign div_ovf  = signed_a && (src_a == INT_MIN) && (src_b == {XLEN{1'b1}});

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            default: alu_res = '0;
        endcase
    end

    // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc, mul_prod;
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    assign mul_acc  = {mul_sum, acc_reg[XLEN-1:1]};
    assign mul_prod = neg_reg ? -mul_acc : mul_acc;

    // Divide: upper half is the partial remainder, lower half dividend -> quotient.
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_acc;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_reg};
    assign div_sub   = div_shift[XLEN-1:0] - opnd_reg;
    assign div_acc   = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_reg[XLEN-2:0], div_ge};
    assign quot_fix  = neg_reg ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
    assign rem_fix   = neg_rem_reg ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        acc_next     = acc_reg;
        opnd_next    = opnd_reg;
        neg_next     = neg_reg;
        neg_rem_next = neg_rem_reg;
        sel_next     = sel_reg;
        result_next  = result_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            IDLE: if (in_valid) begin
                illegal_next = (op == OP_ILL);
                result_next  = alu_res;
                state_next   = DONE;
                case (op)
                    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                        state_next = MUL;
                        count_next = CNT_FULL;
                        acc_next   = {{XLEN{1'b0}}, mag_b};
                        opnd_next  = mag_a;
                        neg_next   = neg_a ^ neg_b;
                        sel_next   = (op != OP_MUL);
                    end
                    OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                        sel_next = is_rem;
                        if (src_b == '0) begin
                            result_next = is_rem ? src_a : {XLEN{1'b1}};
                        end else if (div_ovf) begin
                            result_next = is_rem ? '0 : INT_MIN;
                        end else begin
                            state_next   = DIV;
                            count_next   = CNT_FULL;
                            acc_next     = {{XLEN{1'b0}}, mag_a};
                            opnd_next    = mag_b;
                            neg_next     = neg_a ^ neg_b;
                            neg_rem_next = neg_a;
                        end
                    end
                    default: ;
                endcase
            end
            MUL: begin
                acc_next   = mul_acc;
                count_next = count_reg - CNT_ONE;
                if (count_reg == CNT_ONE) begin
                    result_next = sel_reg ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
                    state_next  = DONE;
                end
            end
            DIV: begin
                acc_next   = div_acc;
                count_next = count_reg - CNT_ONE;
                if (count_reg == CNT_ONE) begin
                    result_next = sel_reg ? rem_fix : quot_fix;
                    state_next  = DONE;
                end
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            neg_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            sel_reg     <= 1'b0;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            opnd_reg    <= opnd_next;
            neg_reg     <= neg_next;
            neg_rem_reg <= neg_rem_next;
            sel_reg     <= sel_next;
            result_reg  <= result_next;
            illegal_reg <= illegal_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = (result_reg == '0);
    assign illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: arithmetic reference model, scoreboard compare on every
// output-valid cycle, randomized ops plus hand-computed pins.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     alu_op = ALU_OP__MEMORY_ACCESS;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_txn = 0;

    typedef struct {
        logic [31:0] res;
        bit          ill;
        int          lat;
        int          acc_cyc;
        bit          seen;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
        int sa;
        sa = a;
        return sa >>> sh;
    endfunction

    function automatic logic [31:0] base_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: return a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void model(input alu_op_t op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output int lat);
        int sa;
        int sb;
        longint p;
        longint unsigned pu;
        bit ovf;
        sa = a;
        sb = b;
        r = '0;
        ill = 1'b0;
        lat = 1;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_OP__MEMORY_ACCESS: r = a + b;
            ALU_OP__BRANCH:        r = a - b;
            ALU_OP__UNSET:         r = (f3 == 3'd5 && f7[5]) ? sra(a, b[4:0]) : base_alu(f3, a, b);
            default: begin
                if (f7 == 7'h00) r = base_alu(f3, a, b);
                else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) r = sra(a, b[4:0]);
                else if (f7 == 7'h01) begin
                    lat = 33;
                    case (f3)
                        3'd0: r = a * b;
                        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
                        3'd2: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
                        3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
                        3'd4: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                              else if (ovf) begin r = 32'h8000_0000; lat = 1; end
                              else r = sa / sb;
                        3'd5: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                              else r = a / b;
                        3'd6: if (b == 0) begin r = a; lat = 1; end
                              else if (ovf) begin r = 32'h0; lat = 1; end
                              else r = sa % sb;
                        default: if (b == 0) begin r = a; lat = 1; end
                                 else r = a % b;
                    endcase
                end else ill = 1'b1;
            end
        endcase
    endfunction

    // Scoreboard: every accepted request is predicted here and checked while out_valid is high.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] r;
        bit          ill;
        int          lat;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, exp_q.size() == 0);
            if (exp_q.size() == 0) begin
                chk("out_valid_idle", out_valid, 0);
            end else begin
                e = exp_q[0];
                if (out_valid) begin
                    if (!e.seen) begin
                        chk("latency", cyc - e.acc_cyc, e.lat);
                        exp_q[0].seen = 1'b1;
                    end
                    chk("result", result, e.res);
                    chk("zero", zero, e.res == 0);
                    chk("illegal", illegal, e.ill);
                    if (out_ready) begin
                        n_txn++;
                        $display("txn %0d: result=%08h zero=%0d illegal=%0d latency=%0d",
                                 n_txn, result, zero, illegal, e.lat);
                        void'(exp_q.pop_front());
                    end
                end else if (cyc - e.acc_cyc == e.lat) begin
                    chk("out_valid_due", out_valid, 1);
                end
            end
            if (in_valid && in_ready) begin
                model(alu_op, funct3, funct7, src_a, src_b, r, ill, lat);
                exp_q.push_back('{r, ill, lat, cyc, 1'b0});
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic scramble();
        alu_op = alu_op_t'($urandom_range(0, 3));
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        src_a  = 32'($urandom);
        src_b  = 32'($urandom);
    endtask

    task automatic accept_op(input alu_op_t op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        alu_op = op; funct3 = f3; funct7 = f7; src_a = a; src_b = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready=%0d, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // mode 0: out_ready tied high, 1: random out_ready, 2: hold off 10 cycles then pulse
    task automatic finish_op(input int mode);
        int t = 0;
        int held = 0;
        out_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        forever begin
            if (out_valid && out_ready) begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                n_cmp++; n_err++;
                $display("FAIL completion_timeout: out_valid=%0d out_ready=%0d, required handshake", out_valid, out_ready);
                break;
            end
            if (!out_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                scramble();
            end else begin
                in_valid = 1'b0;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: if (out_valid) begin
                    held++;
                    if (held == 5) chk("hold_in_ready", in_ready, 0);
                    out_ready = (held > 10);
                end
            endcase
        end
        in_valid = 1'b0;
    endtask

    task automatic do_op(input alu_op_t op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input int mode);
        accept_op(op, f3, f7, a, b);
        finish_op(mode);
    endtask

    task automatic pin(input string name, input alu_op_t op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want_r, input bit want_ill, input int want_lat);
        logic [31:0] r;
        bit          ill;
        int          lat;
        model(op, f3, f7, a, b, r, ill, lat);
        chk({name, "_model_res"}, r, want_r);
        chk({name, "_model_ill"}, ill, want_ill);
        chk({name, "_model_lat"}, lat, want_lat);
        do_op(op, f3, f7, a, b, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_illegal", illegal, 0);
        reset_n = 1'b1;

        pin("add",    ALU_OP__MEMORY_ACCESS,      3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 0, 1);
        pin("branch", ALU_OP__BRANCH,             3'd0, 7'h00, 32'd9, 32'd9, 32'd0, 0, 1);
        pin("sra",    ALU_OP__REGISTER_OPERATION, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
        pin("srai",   ALU_OP__UNSET,              3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
        pin("srli",   ALU_OP__UNSET,              3'd5, 7'h00, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1);
        pin("mulh",   ALU_OP__REGISTER_OPERATION, 3'd1, 7'h01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 0, 33);
        pin("mul",    ALU_OP__REGISTER_OPERATION, 3'd0, 7'h01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0, 33);
        pin("mulhu",  ALU_OP__REGISTER_OPERATION, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33);
        pin("div",    ALU_OP__REGISTER_OPERATION, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 33);
        pin("rem",    ALU_OP__REGISTER_OPERATION, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 33);
        pin("divu0",  ALU_OP__REGISTER_OPERATION, 3'd5, 7'h01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 1);
        pin("removf", ALU_OP__REGISTER_OPERATION, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1);
        pin("ill",    ALU_OP__REGISTER_OPERATION, 3'd0, 7'h10, 32'd3, 32'd4, 32'd0, 1, 1);

        do_op(ALU_OP__REGISTER_OPERATION, 3'd4, 7'h01, 32'd1000, 32'd7, 2);
        chk("pulse_idle_in_ready", in_ready, 1);
        chk("pulse_idle_out_valid", out_valid, 0);

        accept_op(ALU_OP__REGISTER_OPERATION, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_zero", zero, 1);
        chk("midrst_illegal", illegal, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_op(ALU_OP__MEMORY_ACCESS, 3'd0, 7'h00, 32'd40, 32'd2, 0);

        for (int i = 0; i < 250; i++) begin
            alu_op_t     op;
            logic [6:0]  f7;
            op = alu_op_t'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2, 3: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            do_op(op, 3'($urandom), f7, pick(), pick(), ($urandom_range(0, 19) == 0) ? 2 : $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
